video_pattern_sched: RTL and testbench

Frame-synchronous controller for the colour-bar/test-pattern generator in the HDMI video path. It owns the generator's reset, so it decides when video starts and stops. It accepts pattern configuration from the host over a valid/ready handshake and applies each change only at a frame boundary (rising edge of the generator's vertical sync). In auto mode it steps through the patterns after a programmable number of frames.

---
 rtl/video_pattern_sched_if.sv | 22 ++
 rtl/video_pattern_sched.sv | 122 ++++++++++++
 tb/tb_video_pattern_sched.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_sched_if.sv
// rtl/video_pattern_sched_if.sv - host configuration handshake for the test-pattern scheduler
interface video_pattern_sched_if #(
    parameter int NUM_PAT = 8,
    parameter int DWELL_W = 8
);
    logic                       cfg_valid;
    logic                       cfg_ready;
    logic                       cfg_run;
    logic                       cfg_auto;
    logic [$clog2(NUM_PAT)-1:0] cfg_pat;
    logic [DWELL_W-1:0]         cfg_dwell;

    modport master (
        output cfg_valid, cfg_run, cfg_auto, cfg_pat, cfg_dwell,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_run, cfg_auto, cfg_pat, cfg_dwell,
        output cfg_ready
    );
endinterface

// File: rtl/video_pattern_sched.sv
// rtl/video_pattern_sched.sv - frame-synchronous pattern scheduler and generator reset owner
module video_pattern_sched #(
    parameter int  NUM_PAT = 8,
    parameter int  DWELL_W = 8,
    localparam int PAT_W   = $clog2(NUM_PAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vs_in,
    input  logic                 de_in,
    video_pattern_sched_if.slave cfg,
    output logic                 gen_rst,
    output logic [PAT_W-1:0]     pat_sel,
    output logic                 pat_update,
    output logic [15:0]          frame_cnt,
    output logic                 sync_err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);

    logic [1:0]         state;
    logic               vs_d;
    logic               act_auto;
    logic [DWELL_W-1:0] act_dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               pend_v;
    logic               pend_run;
    logic               pend_auto;
    logic [PAT_W-1:0]   pend_pat;
    logic [DWELL_W-1:0] pend_dwell;

    logic vs_rise;
    logic xfer;

    assign vs_rise       = vs_in & ~vs_d;
    assign cfg.cfg_ready = ~pend_v;
    assign xfer          = cfg.cfg_valid & ~pend_v;

    // gen_rst is registered rather than decoded from state so the generator never sees a glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            vs_d       <= 1'b0;
            gen_rst    <= 1'b1;
            pat_sel    <= '0;
            pat_update <= 1'b0;
            frame_cnt  <= '0;
            sync_err   <= 1'b0;
            act_auto   <= 1'b0;
            act_dwell  <= '0;
            dwell_cnt  <= '0;
            pend_v     <= 1'b0;
            pend_run   <= 1'b0;
            pend_auto  <= 1'b0;
            pend_pat   <= '0;
            pend_dwell <= '0;
        end else begin
            vs_d       <= vs_in;
            pat_update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        act_auto   <= cfg.cfg_auto;
                        act_dwell  <= cfg.cfg_dwell;
                        pat_sel    <= cfg.cfg_pat;
                        pat_update <= 1'b1;
                        dwell_cnt  <= '0;
                        if (cfg.cfg_run) begin
                            gen_rst   <= 1'b0;
                            frame_cnt <= '0;
                            state     <= ST_START;
                        end
                    end
                end
                ST_START, ST_RUN: begin
                    // A transfer landing on a vs_rise edge is only queued; pend_v is still 0 for this edge
                    if (xfer) begin
                        pend_v     <= 1'b1;
                        pend_run   <= cfg.cfg_run;
                        pend_auto  <= cfg.cfg_auto;
                        pend_pat   <= cfg.cfg_pat;
                        pend_dwell <= cfg.cfg_dwell;
                    end
                    if (vs_rise) begin
                        if (de_in)
                            sync_err <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= ST_RUN;
                        if (pend_v) begin
                            pend_v     <= 1'b0;
                            act_auto   <= pend_auto;
                            act_dwell  <= pend_dwell;
                            pat_sel    <= pend_pat;
                            pat_update <= 1'b1;
                            dwell_cnt  <= '0;
                            if (!pend_run) begin
                                gen_rst   <= 1'b1;
                                frame_cnt <= frame_cnt;
                                state     <= ST_IDLE;
                            end
                        end else if (act_auto && dwell_cnt == act_dwell) begin
                            pat_sel    <= (pat_sel == PAT_LAST) ? '0 : pat_sel + PAT_W'(1);
                            pat_update <= 1'b1;
                            dwell_cnt  <= '0;
                        end else if (act_auto) begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end else begin
                            dwell_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    gen_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_video_pattern_sched.sv
// tb/tb_video_pattern_sched.sv - scenario tasks plus a pat_update scoreboard for video_pattern_sched
module tb_video_pattern_sched;
    localparam int NUM_PAT = 8;
    localparam int DWELL_W = 8;
    localparam int PAT_W   = 3;
    localparam logic [PAT_W-1:0] AUTO_SEQ [6] = '{3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vs_in = 1'b0;
    logic             de_in = 1'b0;
    logic             gen_rst;
    logic [PAT_W-1:0] pat_sel;
    logic             pat_update;
    logic [15:0]      frame_cnt;
    logic             sync_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [PAT_W-1:0] exp_q[$];
    logic [PAT_W-1:0] exp_pat;
    logic             prev_upd = 1'b0;

    video_pattern_sched_if #(.NUM_PAT(NUM_PAT), .DWELL_W(DWELL_W)) cfg ();

    video_pattern_sched #(.NUM_PAT(NUM_PAT), .DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .vs_in      (vs_in),
        .de_in      (de_in),
        .cfg        (cfg),
        .gen_rst    (gen_rst),
        .pat_sel    (pat_sel),
        .pat_update (pat_update),
        .frame_cnt  (frame_cnt),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pat_update must match the next queued pattern load
    always @(posedge clk) begin
        #1;
        if (pat_update) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: pat_update with pat_sel=%0d, required no load", pat_sel);
            end else begin
                exp_pat = exp_q.pop_front();
                if (pat_sel !== exp_pat) begin
                    n_err++;
                    $display("FAIL sb_pat: pat_sel=%0d required %0d", pat_sel, exp_pat);
                end
            end
            n_cmp++;
            if (prev_upd) begin
                n_err++;
                $display("FAIL sb_pulse_width: pat_update high in consecutive cycles, required single-cycle");
            end
        end
        prev_upd = pat_update;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vs_in = 1'b0;
        de_in = 1'b0;
        cfg.cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send_cfg(input logic run, input logic auto_m, input logic [PAT_W-1:0] pat,
                            input logic [DWELL_W-1:0] dwell);
        bit ok = 0;
        cfg.cfg_run   = run;
        cfg.cfg_auto  = auto_m;
        cfg.cfg_pat   = pat;
        cfg.cfg_dwell = dwell;
        cfg.cfg_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cfg.cfg_ready === 1'b1) ok = 1;
            tick();
        end
        cfg.cfg_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL cfg_timeout: cfg_ready=%b after 200 cycles, required 1", cfg.cfg_ready);
        end
    endtask

    // Returns one step after the rising-edge sample of vs_in
    task automatic vs_pulse();
        vs_in = 1'b0;
        tick();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
    endtask

    task automatic active_video(input int k);
        de_in = 1'b1;
        repeat (k) tick();
        de_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++; if (gen_rst !== 1'b1) begin n_err++; $display("FAIL rst_gen_rst: got %b required 1", gen_rst); end
        n_cmp++; if (pat_sel !== 3'd0) begin n_err++; $display("FAIL rst_pat_sel: got %0d required 0", pat_sel); end
        n_cmp++; if (pat_update !== 1'b0) begin n_err++; $display("FAIL rst_pat_update: got %b required 0", pat_update); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
        n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL rst_sync_err: got %b required 0", sync_err); end
        n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready: got %b required 1", cfg.cfg_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start_fixed();
        do_reset();
        exp_q.push_back(3'd3);
        send_cfg(1'b1, 1'b0, 3'd3, 8'd0);
        n_cmp++; if (gen_rst !== 1'b0) begin n_err++; $display("FAIL start_gen_rst: got %b required 0", gen_rst); end
        n_cmp++; if (pat_sel !== 3'd3) begin n_err++; $display("FAIL start_pat_sel: got %0d required 3", pat_sel); end
        n_cmp++; if (pat_update !== 1'b1) begin n_err++; $display("FAIL start_pat_update: got %b required 1", pat_update); end
        tick();
        n_cmp++; if (pat_update !== 1'b0) begin n_err++; $display("FAIL start_pulse_end: got %b required 0", pat_update); end
        vs_pulse();
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL start_frame1: got %0d required 1", frame_cnt); end
        for (int i = 0; i < 10; i++) begin
            active_video(3);
            vs_pulse();
            n_cmp++; if (pat_sel !== 3'd3) begin n_err++; $display("FAIL fixed_hold: frame %0d pat_sel=%0d required 3", i, pat_sel); end
            n_cmp++; if (frame_cnt !== 16'(i + 2)) begin n_err++; $display("FAIL fixed_frame_cnt: got %0d required %0d", frame_cnt, i + 2); end
        end
    endtask

    task automatic test_auto_cycle();
        logic [PAT_W-1:0] prev = 3'd6;
        do_reset();
        exp_q.push_back(3'd6);
        send_cfg(1'b1, 1'b1, 3'd6, 8'd1);
        for (int i = 0; i < 6; i++) begin
            if (AUTO_SEQ[i] != prev) exp_q.push_back(AUTO_SEQ[i]);
            prev = AUTO_SEQ[i];
            active_video(2);
            vs_pulse();
            n_cmp++; if (pat_sel !== AUTO_SEQ[i]) begin n_err++; $display("FAIL auto_seq: vs %0d pat_sel=%0d required %0d", i + 1, pat_sel, AUTO_SEQ[i]); end
        end
    endtask

    task automatic test_dwell_max();
        do_reset();
        exp_q.push_back(3'd0);
        send_cfg(1'b1, 1'b1, 3'd0, 8'd255);
        for (int i = 1; i <= 256; i++) begin
            if (i == 256) exp_q.push_back(3'd1);
            vs_pulse();
            if (i == 255) begin
                n_cmp++; if (pat_sel !== 3'd0) begin n_err++; $display("FAIL dwell_max_hold: pat_sel=%0d required 0", pat_sel); end
            end
            if (i == 256) begin
                n_cmp++; if (pat_sel !== 3'd1) begin n_err++; $display("FAIL dwell_max_step: pat_sel=%0d required 1", pat_sel); end
            end
        end
        n_cmp++; if (frame_cnt !== 16'd256) begin n_err++; $display("FAIL dwell_max_frames: got %0d required 256", frame_cnt); end
    endtask

    task automatic test_mid_frame();
        do_reset();
        exp_q.push_back(3'd2);
        send_cfg(1'b1, 1'b0, 3'd2, 8'd0);
        vs_pulse();
        de_in = 1'b1;
        tick();
        exp_q.push_back(3'd5);
        send_cfg(1'b1, 1'b0, 3'd5, 8'd0);
        n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_low: got %b required 0", cfg.cfg_ready); end
        tick();
        tick();
        de_in = 1'b0;
        tick();
        n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_hold: got %b required 0", cfg.cfg_ready); end
        n_cmp++; if (pat_sel !== 3'd2) begin n_err++; $display("FAIL mid_early_apply: pat_sel=%0d required 2", pat_sel); end
        vs_pulse();
        n_cmp++; if (pat_sel !== 3'd5) begin n_err++; $display("FAIL mid_apply: pat_sel=%0d required 5", pat_sel); end
        n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_back: got %b required 1", cfg.cfg_ready); end
    endtask

    task automatic test_same_edge();
        vs_in = 1'b0;
        tick();
        cfg.cfg_run   = 1'b1;
        cfg.cfg_auto  = 1'b0;
        cfg.cfg_pat   = 3'd1;
        cfg.cfg_dwell = 8'd0;
        cfg.cfg_valid = 1'b1;
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        cfg.cfg_valid = 1'b0;
        n_cmp++; if (pat_sel !== 3'd5) begin n_err++; $display("FAIL same_edge_early: pat_sel=%0d required 5", pat_sel); end
        n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_err++; $display("FAIL same_edge_pending: cfg_ready=%b required 0", cfg.cfg_ready); end
        exp_q.push_back(3'd1);
        active_video(3);
        vs_pulse();
        n_cmp++; if (pat_sel !== 3'd1) begin n_err++; $display("FAIL same_edge_apply: pat_sel=%0d required 1", pat_sel); end
    endtask

    task automatic test_stop_restart();
        do_reset();
        exp_q.push_back(3'd4);
        send_cfg(1'b1, 1'b0, 3'd4, 8'd0);
        repeat (3) begin
            vs_pulse();
            active_video(2);
        end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL stop_pre_frames: got %0d required 3", frame_cnt); end
        de_in = 1'b1;
        tick();
        exp_q.push_back(3'd2);
        send_cfg(1'b0, 1'b0, 3'd2, 8'd0);
        de_in = 1'b0;
        tick();
        n_cmp++; if (gen_rst !== 1'b0) begin n_err++; $display("FAIL stop_early: gen_rst=%b required 0", gen_rst); end
        vs_pulse();
        n_cmp++; if (gen_rst !== 1'b1) begin n_err++; $display("FAIL stop_gen_rst: got %b required 1", gen_rst); end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL stop_frame_cnt: got %0d required 3", frame_cnt); end
        n_cmp++; if (pat_sel !== 3'd2) begin n_err++; $display("FAIL stop_pat_sel: got %0d required 2", pat_sel); end
        repeat (2) begin
            active_video(2);
            vs_pulse();
        end
        n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL stop_frozen: frame_cnt=%0d required 3", frame_cnt); end
        n_cmp++; if (gen_rst !== 1'b1) begin n_err++; $display("FAIL stop_idle: gen_rst=%b required 1", gen_rst); end
        exp_q.push_back(3'd7);
        send_cfg(1'b1, 1'b0, 3'd7, 8'd0);
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL restart_frame_cnt: got %0d required 0", frame_cnt); end
        n_cmp++; if (gen_rst !== 1'b0) begin n_err++; $display("FAIL restart_gen_rst: got %b required 0", gen_rst); end
        vs_pulse();
        n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL restart_frame1: got %0d required 1", frame_cnt); end
    endtask

    task automatic test_reset_error();
        do_reset();
        exp_q.push_back(3'd0);
        send_cfg(1'b1, 1'b0, 3'd0, 8'd0);
        vs_pulse();
        de_in = 1'b1;
        tick();
        send_cfg(1'b1, 1'b0, 3'd7, 8'd0);
        n_cmp++; if (cfg.cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_pending: cfg_ready=%b required 0", cfg.cfg_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (gen_rst !== 1'b1) begin n_err++; $display("FAIL rst_mid_gen_rst: got %b required 1", gen_rst); end
        n_cmp++; if (cfg.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b required 1", cfg.cfg_ready); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_frame_cnt: got %0d required 0", frame_cnt); end
        n_cmp++; if (pat_sel !== 3'd0) begin n_err++; $display("FAIL rst_mid_pat_sel: got %0d required 0", pat_sel); end
        tick();
        rst = 1'b0;
        de_in = 1'b0;
        repeat (2) vs_pulse();
        n_cmp++; if (gen_rst !== 1'b1 || frame_cnt !== 16'd0) begin n_err++; $display("FAIL idle_ignores_vs: gen_rst=%b frame_cnt=%0d required 1/0", gen_rst, frame_cnt); end
        exp_q.push_back(3'd2);
        send_cfg(1'b1, 1'b0, 3'd2, 8'd0);
        vs_pulse();
        n_cmp++; if (pat_sel !== 3'd2) begin n_err++; $display("FAIL rst_pending_lost: pat_sel=%0d required 2", pat_sel); end
        vs_in = 1'b0;
        de_in = 1'b1;
        tick();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        de_in = 1'b0;
        n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_err_set: got %b required 1", sync_err); end
        repeat (2) begin
            active_video(2);
            vs_pulse();
        end
        n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_err_sticky: got %b required 1", sync_err); end
        rst = 1'b1;
        tick();
        n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_err_clear: got %b required 0", sync_err); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        cfg.cfg_valid = 1'b0;
        cfg.cfg_run   = 1'b0;
        cfg.cfg_auto  = 1'b0;
        cfg.cfg_pat   = '0;
        cfg.cfg_dwell = '0;
        test_reset();
        test_start_fixed();
        test_auto_cycle();
        test_dwell_max();
        test_mid_frame();
        test_same_edge();
        test_stop_restart();
        test_reset_error();
        repeat (2) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected loads never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
